// File: rtl/hazard_pkg.sv
// Shared types and constants for the load-use hazard / bubble injection unit.
package hazard_pkg;

  // Load-use FSM state encoding
  typedef enum logic {
    IDLE     = 1'b0,
    LU_STALL = 1'b1
  } hz_state_t;

  // Control-word bit positions: {write, ALUop[1:0], MemtoReg, MemRead, MemWrite, regdst, ALUsrc}
  localparam int unsigned CW_WRITE    = 7;
  localparam int unsigned CW_ALUOP_HI = 6;
  localparam int unsigned CW_ALUOP_LO = 5;
  localparam int unsigned CW_MEMTOREG = 4;
  localparam int unsigned CW_MEMREAD  = 3;
  localparam int unsigned CW_MEMWRITE = 2;
  localparam int unsigned CW_REGDST   = 1;
  localparam int unsigned CW_ALUSRC   = 0;

  // Stall counter width (supports up to 15 stall cycles)
  localparam int unsigned CNT_W = 4;

  // Bubble: write disabled, ALUop=2'b11, everything else off (8'h60)
  localparam logic [7:0] BUBBLE_DEFAULT =
    8'((1 << CW_ALUOP_HI) | (1 << CW_ALUOP_LO));

endpackage

// File: rtl/hazard_stall_unit_if.sv
// ID-stage hazard signals: decode/EX inputs in, pipeline enables and control word out.
interface hazard_stall_unit_if #(
  parameter int unsigned CTRL_W = 8,
  parameter int unsigned REG_AW = 5
);
  logic [CTRL_W-1:0] ctrl_in;
  logic [REG_AW-1:0] if_id_rs;
  logic [REG_AW-1:0] if_id_rt;
  logic              if_id_uses_rt;
  logic              id_ex_memread;
  logic [REG_AW-1:0] id_ex_rt;
  logic              flush;
  logic              ext_stall;
  logic [CTRL_W-1:0] ctrl_out;
  logic              pc_write;
  logic              if_id_write;
  logic              id_ex_write;
  logic              if_id_flush;
  logic              lu_busy;

  modport master (
    output ctrl_in, if_id_rs, if_id_rt, if_id_uses_rt, id_ex_memread, id_ex_rt,
           flush, ext_stall,
    input  ctrl_out, pc_write, if_id_write, id_ex_write, if_id_flush, lu_busy
  );

  modport slave (
    input  ctrl_in, if_id_rs, if_id_rt, if_id_uses_rt, id_ex_memread, id_ex_rt,
           flush, ext_stall,
    output ctrl_out, pc_write, if_id_write, id_ex_write, if_id_flush, lu_busy
  );
endinterface

// File: rtl/hazard_stall_cnt.sv
// Loadable, freezable 4-bit down-counter; term flags the last remaining stall cycle.
module hazard_stall_cnt
  import hazard_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             term
);

  logic [CNT_W-1:0] cnt;

  // Clear beats load beats decrement; no wrap below zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 cnt <= '0;
    else if (clr)               cnt <= '0;
    else if (load)              cnt <= load_val;
    else if (dec && cnt != '0)  cnt <= cnt - CNT_W'(1);
  end

  assign term = (cnt == CNT_W'(1));

endmodule

// File: rtl/hazard_stall_unit.sv
// Load-use hazard detector and bubble injector between ID decode and ID/EX.
// Priority: flush > ext_stall > load-use stall > normal.
// Optional macro HAZ_PERF_CNT_EN adds a saturating stall-cycle counter output.
module hazard_stall_unit
  import hazard_pkg::*;
#(
  parameter int unsigned       CTRL_W     = 8,
  parameter logic [CTRL_W-1:0] BUBBLE_VAL = CTRL_W'(BUBBLE_DEFAULT),
  parameter int unsigned       REG_AW     = 5,
  parameter int unsigned       LU_CYCLES  = 1
)(
  input  logic               clk,
  input  logic               rst_n,
  hazard_stall_unit_if.slave bus
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0]        perf_stall_cnt
`endif
);

  localparam logic [CNT_W-1:0] LU_RELOAD = CNT_W'(LU_CYCLES - 1);

  hz_state_t state, state_nxt;
  logic      lu_hit;
  logic      stall_take;
  logic      cnt_clr, cnt_load, cnt_dec, cnt_term;

  // Load in EX writes a register the ID instruction reads ($zero never hazards)
  assign lu_hit = bus.id_ex_memread & (bus.id_ex_rt != '0) &
                  ((bus.id_ex_rt == bus.if_id_rs) |
                   (bus.if_id_uses_rt & (bus.id_ex_rt == bus.if_id_rt)));

  // Stall branch wins this cycle (nothing of higher priority active)
  assign stall_take = rst_n & ~bus.flush & ~bus.ext_stall &
                      ((state == LU_STALL) | lu_hit);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state, counter control and same-cycle pipeline controls
  always_comb begin
    state_nxt       = state;
    cnt_clr         = 1'b0;
    cnt_load        = 1'b0;
    cnt_dec         = 1'b0;
    bus.ctrl_out    = bus.ctrl_in;
    bus.pc_write    = 1'b1;
    bus.if_id_write = 1'b1;
    bus.id_ex_write = 1'b1;
    bus.if_id_flush = 1'b0;
    bus.lu_busy     = 1'b0;
    if (!rst_n) begin
      state_nxt       = IDLE;
      bus.ctrl_out    = BUBBLE_VAL;
      bus.pc_write    = 1'b0;
      bus.if_id_write = 1'b0;
      bus.id_ex_write = 1'b0;
    end else if (bus.flush) begin
      state_nxt       = IDLE;
      cnt_clr         = 1'b1;
      bus.ctrl_out    = BUBBLE_VAL;
      bus.if_id_flush = 1'b1;
    end else if (bus.ext_stall) begin
      bus.pc_write    = 1'b0;
      bus.if_id_write = 1'b0;
      bus.id_ex_write = 1'b0;
      bus.lu_busy     = (state == LU_STALL);
    end else if (stall_take) begin
      bus.ctrl_out    = BUBBLE_VAL;
      bus.pc_write    = 1'b0;
      bus.if_id_write = 1'b0;
      bus.lu_busy     = 1'b1;
      if (state == IDLE) begin
        if (LU_CYCLES > 1) begin
          state_nxt = LU_STALL;
          cnt_load  = 1'b1;
        end
      end else begin
        cnt_dec = 1'b1;
        if (cnt_term) state_nxt = IDLE;
      end
    end
  end

  hazard_stall_cnt u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (cnt_clr),
    .load     (cnt_load),
    .load_val (LU_RELOAD),
    .dec      (cnt_dec),
    .term     (cnt_term)
  );

`ifdef HAZ_PERF_CNT_EN
  // Saturating count of cycles spent in the load-use stall branch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                      perf_stall_cnt <= '0;
    else if (stall_take && perf_stall_cnt != '1)     perf_stall_cnt <= perf_stall_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Bench for hazard_stall_unit: two instances (LU_CYCLES=1 and 3) on shared stimulus,
// a remaining-stall-cycles reference model, directed literal checks and random traffic.
module tb_hazard_stall_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] ctrl_in;
  logic [4:0] rs, rt, ex_rt;
  logic       uses_rt, memread, flush, ext_stall;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  hazard_stall_unit_if #(.CTRL_W(8), .REG_AW(5)) b1 ();
  hazard_stall_unit_if #(.CTRL_W(8), .REG_AW(5)) b3 ();

  assign b1.ctrl_in = ctrl_in;   assign b3.ctrl_in = ctrl_in;
  assign b1.if_id_rs = rs;       assign b3.if_id_rs = rs;
  assign b1.if_id_rt = rt;       assign b3.if_id_rt = rt;
  assign b1.if_id_uses_rt = uses_rt; assign b3.if_id_uses_rt = uses_rt;
  assign b1.id_ex_memread = memread; assign b3.id_ex_memread = memread;
  assign b1.id_ex_rt = ex_rt;    assign b3.id_ex_rt = ex_rt;
  assign b1.flush = flush;       assign b3.flush = flush;
  assign b1.ext_stall = ext_stall; assign b3.ext_stall = ext_stall;

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] perf1, perf3;
`endif

  hazard_stall_unit #(.LU_CYCLES(1)) u1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b1)
`ifdef HAZ_PERF_CNT_EN
    , .perf_stall_cnt (perf1)
`endif
  );

  hazard_stall_unit #(.LU_CYCLES(3)) u3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b3)
`ifdef HAZ_PERF_CNT_EN
    , .perf_stall_cnt (perf3)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: stall cycles still owed, and stall cycles counted so far
  int          rem   [2] = '{0, 0};
  int          rem_n [2] = '{0, 0};
  logic [31:0] perf_m[2] = '{32'd0, 32'd0};
  logic [31:0] perf_n[2] = '{32'd0, 32'd0};
  int          lu_len[2] = '{1, 3};

  always @(negedge clk) begin : model_cmp
    logic       hit;
    logic [7:0] e_ctrl;
    logic       e_pc, e_ifid, e_idex, e_fl, e_busy;
    logic [12:0] act, exp;
    logic [31:0] e_perf;
    hit = memread && (ex_rt != 5'd0) && (ex_rt == rs || (uses_rt && ex_rt == rt));
    for (int k = 0; k < 2; k++) begin
      e_ctrl = ctrl_in; e_pc = 1; e_ifid = 1; e_idex = 1; e_fl = 0; e_busy = 0;
      rem_n[k]  = rem[k];
      perf_n[k] = perf_m[k];
      e_perf    = perf_m[k];
      if (!rst_n) begin
        e_ctrl = 8'h60; e_pc = 0; e_ifid = 0; e_idex = 0;
        rem_n[k] = 0; perf_n[k] = 0; e_perf = 0;
      end else if (flush) begin
        e_ctrl = 8'h60; e_fl = 1;
        rem_n[k] = 0;
      end else if (ext_stall) begin
        e_pc = 0; e_ifid = 0; e_idex = 0;
        e_busy = (rem[k] > 0);
      end else if (rem[k] > 0 || hit) begin
        e_ctrl = 8'h60; e_pc = 0; e_ifid = 0; e_busy = 1;
        rem_n[k] = (rem[k] > 0) ? rem[k] - 1 : lu_len[k] - 1;
        if (perf_m[k] != 32'hFFFF_FFFF) perf_n[k] = perf_m[k] + 1;
      end
      exp = {e_ctrl, e_pc, e_ifid, e_idex, e_fl, e_busy};
      if (k == 0)
        act = {b1.ctrl_out, b1.pc_write, b1.if_id_write, b1.id_ex_write, b1.if_id_flush, b1.lu_busy};
      else
        act = {b3.ctrl_out, b3.pc_write, b3.if_id_write, b3.id_ex_write, b3.if_id_flush, b3.lu_busy};
      check(k == 0 ? "model_lu1" : "model_lu3", 32'(act), 32'(exp));
`ifdef HAZ_PERF_CNT_EN
      check(k == 0 ? "perf_lu1" : "perf_lu3", (k == 0) ? perf1 : perf3, e_perf);
`endif
    end
  end

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      rem[k]    = rem_n[k];
      perf_m[k] = perf_n[k];
    end
  end

  task automatic to_drive();
    @(posedge clk); #1;
  endtask

  task automatic to_sample();
    @(negedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0; ctrl_in = 8'hFF; rs = '0; rt = '0; ex_rt = '0;
    uses_rt = 1'b0; memread = 1'b0; flush = 1'b0; ext_stall = 1'b0;

    // Reset forces bubble and closes all enables
    to_sample();
    check("rst_ctrl",  32'(b1.ctrl_out), 32'h60);
    check("rst_en",    32'({b1.pc_write, b1.if_id_write, b1.id_ex_write, b1.if_id_flush}), 32'h0);
    check("rst_ctrl3", 32'(b3.ctrl_out), 32'h60);
    to_drive(); rst_n = 1'b1;
    to_sample();
    check("rel_ctrl", 32'(b1.ctrl_out), 32'hFF);
    check("rel_en",   32'({b1.pc_write, b1.if_id_write, b1.id_ex_write}), 32'h7);

    // Single-cycle load-use on rs
    to_drive(); ctrl_in = 8'hA5; memread = 1'b1; ex_rt = 5'd5; rs = 5'd5;
    to_sample();
    check("lu1_ctrl", 32'(b1.ctrl_out), 32'h60);
    check("lu1_en",   32'({b1.pc_write, b1.if_id_write, b1.id_ex_write, b1.lu_busy}), 32'h3);
    to_drive(); memread = 1'b0;
    to_sample();
    check("lu1_after", 32'({b1.ctrl_out, b1.pc_write, b1.lu_busy}), 32'({8'hA5, 1'b1, 1'b0}));
    repeat (3) to_drive();

    // Three-cycle stall on rt hit; hazard dropped after first cycle must not shorten it
    memread = 1'b1; ex_rt = 5'd7; rs = 5'd3; rt = 5'd7; uses_rt = 1'b1;
    for (int i = 0; i < 3; i++) begin
      to_sample();
      check("lu3_busy", 32'({b3.ctrl_out, b3.lu_busy, b3.pc_write}), 32'({8'h60, 1'b1, 1'b0}));
      to_drive(); memread = 1'b0;
    end
    to_sample();
    check("lu3_done", 32'({b3.lu_busy, b3.pc_write}), 32'h1);

    // rt match ignored when the instruction does not read rt
    to_drive(); memread = 1'b1; uses_rt = 1'b0;
    to_sample();
    check("no_rt_hit", 32'({b1.lu_busy, b3.lu_busy, b3.pc_write}), 32'h1);

    // $zero destination never hazards
    to_drive(); ex_rt = 5'd0; rs = 5'd0;
    to_sample();
    check("zero_reg", 32'({b1.lu_busy, b3.lu_busy, b1.pc_write, b3.pc_write}), 32'h3);

    // Freeze mid-stall: enables closed, stall resumes for the remaining two cycles
    to_drive(); ex_rt = 5'd9; rs = 5'd9;
    to_sample();
    check("frz_s1", 32'(b3.lu_busy), 32'h1);
    to_drive(); memread = 1'b0; ext_stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      to_sample();
      check("frz_en", 32'({b3.ctrl_out, b3.pc_write, b3.if_id_write, b3.id_ex_write}),
            32'({8'hA5, 3'b000}));
      to_drive();
    end
    ext_stall = 1'b0;
    for (int i = 0; i < 2; i++) begin
      to_sample();
      check("frz_resume", 32'({b3.ctrl_out, b3.lu_busy}), 32'({8'h60, 1'b1}));
      to_drive();
    end
    to_sample();
    check("frz_done", 32'({b3.lu_busy, b3.pc_write}), 32'h1);

    // Flush aborts a stall in progress
    to_drive(); memread = 1'b1;
    to_sample();
    check("fl_s1", 32'(b3.lu_busy), 32'h1);
    to_drive(); memread = 1'b0; flush = 1'b1;
    to_sample();
    check("fl_out", 32'({b3.if_id_flush, b3.ctrl_out, b3.pc_write, b3.lu_busy}),
          32'({1'b1, 8'h60, 1'b1, 1'b0}));
    to_drive(); flush = 1'b0;
    to_sample();
    check("fl_after", 32'({b3.ctrl_out, b3.lu_busy, b3.pc_write}), 32'({8'hA5, 1'b0, 1'b1}));

    // Random traffic with frequent hazards, occasional flush/freeze/reset
    for (int i = 0; i < 3000; i++) begin
      to_drive();
      rst_n     = ($urandom_range(0, 199) != 0);
      ctrl_in   = 8'($urandom);
      rs        = 5'($urandom_range(0, 3));
      rt        = 5'($urandom_range(0, 3));
      ex_rt     = 5'($urandom_range(0, 3));
      uses_rt   = 1'($urandom);
      memread   = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 11) == 0);
      ext_stall = ($urandom_range(0, 5) == 0);
    end
    to_drive(); rst_n = 1'b1; flush = 1'b0; ext_stall = 1'b0; memread = 1'b0;
    to_sample();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
